serial_or_16bit_chip: RTL and testbench

SERIAL_OR_16BIT_CHIP -- requirements
Module: serial_or_16bit_chip

---
 rtl/serial_or_16bit_chip_pkg.sv | 18 +
 rtl/serial_or_16bit_chip_if.sv | 32 +++
 rtl/or_chip.sv | 10 +
 rtl/serial_or_16bit_chip_core.sv | 100 ++++++++++
 rtl/serial_or_16bit_chip.sv | 39 +++
 tb/tb_serial_or_16bit_chip.sv | 234 +++++++++++++++++++++++
 6 files changed

// File: rtl/serial_or_16bit_chip_pkg.sv
// Shared definitions for the bit-serial OR engine: default width and FSM encodings.
package serial_or_16bit_chip_pkg;

  localparam int DEF_WIDTH = 16;

  // Fixed encodings so debug probes and checkers can decode the state bus.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bit counter must hold the value WIDTH itself without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_or_16bit_chip_if.sv
// Operand/result bus of the serial OR engine.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both 1. A producer holds its payload stable while valid is 1 and not yet
// accepted; ready may be asserted or dropped independently of valid. Operands
// (a, b) travel on in_valid/in_ready, the result (out) on out_valid/out_ready.
interface serial_or_16bit_chip_if #(
  parameter int WIDTH = serial_or_16bit_chip_pkg::DEF_WIDTH
) ();

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  // Producer of operands / consumer of results.
  modport master (
    output a, b, in_valid, out_ready,
    input  in_ready, out, out_valid, busy
  );

  // The OR engine itself.
  modport slave (
    input  a, b, in_valid, out_ready,
    output in_ready, out, out_valid, busy
  );

endinterface

// File: rtl/or_chip.sv
// Single-bit OR cell; the serial engine reuses one instance for every bit.
module or_chip (
  output logic out,
  input  logic a,
  input  logic b
);

  assign out = a | b;

endmodule

// File: rtl/serial_or_16bit_chip_core.sv
// Bit-serial OR engine: captures a/b, ORs one bit per cycle through a single
// or_chip and presents the assembled result until the consumer takes it.
module serial_or_16bit_chip_core
  import serial_or_16bit_chip_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_or_16bit_chip_if.slave   bus,
  output state_e                  dbg_state_o
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             or_bit;

  // The only OR on the datapath: LSBs of the two operand shift registers.
  or_chip u_or (
    .out (or_bit),
    .a   (a_q[0]),
    .b   (b_q[0])
  );

  // State and datapath registers; reset drops any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      out_q   <= out_d;
    end
  end

  // Next-state and datapath update; out_q changes only on completion so the
  // previous result stays visible while the next one is being built.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          res_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Result fills from the MSB end so bit 0 lands at bit 0 after WIDTH shifts.
        res_d = {or_bit, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          out_d   = res_d;
          state_d = DONE;
        end
      end
      DONE: begin
        // Returning to IDLE costs a cycle, so no operand is taken on this edge.
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status flags are pure state decodes; out comes straight from a register.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out       = out_q;
  assign dbg_state_o   = state_q;

endmodule

// File: rtl/serial_or_16bit_chip.sv
// Top level of the serial OR engine: flat ports bundled onto the internal bus
// and handed to the core.
module serial_or_16bit_chip
  import serial_or_16bit_chip_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output state_e           dbg_state_o
);

  serial_or_16bit_chip_if #(.WIDTH(WIDTH)) bus_if ();

  assign bus_if.a         = a;
  assign bus_if.b         = b;
  assign bus_if.in_valid  = in_valid;
  assign bus_if.out_ready = out_ready;
  assign in_ready         = bus_if.in_ready;
  assign out              = bus_if.out;
  assign out_valid        = bus_if.out_valid;
  assign busy             = bus_if.busy;

  serial_or_16bit_chip_core #(.WIDTH(WIDTH)) u_core (
    .clk         (clk),
    .rst         (reset),
    .bus         (bus_if.slave),
    .dbg_state_o (dbg_state_o)
  );

endmodule

// File: tb/tb_serial_or_16bit_chip.sv
// Directed and randomised checks for the serial OR engine.
module tb_serial_or_16bit_chip;
  import serial_or_16bit_chip_pkg::*;

  localparam int W = 16;
  localparam int WAIT_MAX = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_or_16bit_chip_if #(.WIDTH(W)) bus_if ();
  state_e dbg_state;

  serial_or_16bit_chip #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .a           (bus_if.a),
    .b           (bus_if.b),
    .in_valid    (bus_if.in_valid),
    .in_ready    (bus_if.in_ready),
    .out         (bus_if.out),
    .out_valid   (bus_if.out_valid),
    .out_ready   (bus_if.out_ready),
    .busy        (bus_if.busy),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset            = 1'b1;
    bus_if.a         = '0;
    bus_if.b         = '0;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv);
    int guard = 0;
    while (!bus_if.in_ready && guard < WAIT_MAX) begin
      @(negedge clk);
      guard++;
    end
    check("send_ready_wait", 32'(guard < WAIT_MAX), 1);
    bus_if.a        = av;
    bus_if.b        = bv;
    bus_if.in_valid = 1'b1;
    @(negedge clk);
    bus_if.in_valid = 1'b0;
  endtask

  // Counts rising edges until out_valid is seen; also reports whether busy
  // stayed high on every sample along the way.
  task automatic wait_valid(output int edges, output logic busy_all);
    edges    = 0;
    busy_all = bus_if.busy;
    while (!bus_if.out_valid && edges < WAIT_MAX) begin
      @(negedge clk);
      edges++;
      busy_all = busy_all & bus_if.busy;
    end
  endtask

  task automatic pop_ready();
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    bus_if.out_ready = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int   edges;
    logic busy_all;
    logic ok_out, ok_v, ok_r;
    int   acc[$];
    int   guard;
    logic done;
    logic [W-1:0] av, bv, got;

    // Reset state.
    do_reset();
    check("rst_out", 32'(bus_if.out), 0);
    check("rst_out_valid", 32'(bus_if.out_valid), 0);
    check("rst_in_ready", 32'(bus_if.in_ready), 1);
    check("rst_busy", 32'(bus_if.busy), 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // Basic op. Edges counted after the accepting edge: 16, i.e. out_valid
    // rises on the 17th edge counting the accepting one.
    send(16'h00F0, 16'h0F00);
    check("t1_busy_after_accept", 32'(bus_if.busy), 1);
    check("t1_in_ready_low", 32'(bus_if.in_ready), 0);
    wait_valid(edges, busy_all);
    check("t1_latency", edges, 16);
    check("t1_busy_throughout", 32'(busy_all), 1);
    check("t1_out", 32'(bus_if.out), 32'h0FF0);
    check("t1_state_done", 32'(dbg_state), 32'(DONE));
    pop_ready();
    check("t1_out_valid_cleared", 32'(bus_if.out_valid), 0);
    check("t1_in_ready_back", 32'(bus_if.in_ready), 1);
    check("t1_out_held", 32'(bus_if.out), 32'h0FF0);

    // Backpressure for 10 cycles.
    send(16'hFFFF, 16'h0000);
    wait_valid(edges, busy_all);
    check("t2_latency", edges, 16);
    ok_out = 1'b1; ok_v = 1'b1; ok_r = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ok_out = ok_out & (bus_if.out == 16'hFFFF);
      ok_v   = ok_v & bus_if.out_valid;
      ok_r   = ok_r & !bus_if.in_ready;
    end
    check("t2_out_stable", 32'(ok_out), 1);
    check("t2_valid_stable", 32'(ok_v), 1);
    check("t2_in_ready_low", 32'(ok_r), 1);
    pop_ready();
    check("t2_valid_dropped", 32'(bus_if.out_valid), 0);
    check("t2_in_ready_back", 32'(bus_if.in_ready), 1);

    // Operand and in_valid changes during SHIFT are ignored; out_ready held
    // high during SHIFT is ignored as well.
    bus_if.out_ready = 1'b1;
    send(16'h8001, 16'h4002);
    bus_if.a        = 16'hFFFF;
    bus_if.b        = 16'hFFFF;
    bus_if.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus_if.in_valid = 1'b0;
    wait_valid(edges, busy_all);
    check("t3_latency", edges + 3, 16);
    check("t3_out", 32'(bus_if.out), 32'hC003);
    @(negedge clk);
    check("t3_in_ready_back", 32'(bus_if.in_ready), 1);
    bus_if.out_ready = 1'b0;

    // Reset 8 cycles into SHIFT: cleared with no clock edge.
    send(16'h00FF, 16'hFF00);
    repeat (7) @(negedge clk);
    check("t4_mid_shift", 32'(dbg_state), 32'(SHIFT));
    #2 reset = 1'b1;
    #1;
    check("t4_async_out", 32'(bus_if.out), 0);
    check("t4_async_valid", 32'(bus_if.out_valid), 0);
    check("t4_async_in_ready", 32'(bus_if.in_ready), 1);
    check("t4_async_busy", 32'(bus_if.busy), 0);
    check("t4_async_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    reset = 1'b0;
    send(16'h0001, 16'h0000);
    check("t4_first_accept", 32'(bus_if.busy), 1);
    wait_valid(edges, busy_all);
    check("t4_latency", edges, 16);
    check("t4_out", 32'(bus_if.out), 32'h0001);
    pop_ready();

    // Continuous in_valid with out_ready=1: one accept every 18 cycles.
    bus_if.a         = 16'h0A0A;
    bus_if.b         = 16'h5050;
    bus_if.in_valid  = 1'b1;
    bus_if.out_ready = 1'b1;
    guard = 0;
    while (acc.size() < 4 && guard < 200) begin
      if (bus_if.in_ready) acc.push_back(cyc);
      @(negedge clk);
      guard++;
    end
    bus_if.in_valid = 1'b0;
    check("t5_accepts", acc.size(), 4);
    for (int i = 1; i < acc.size(); i++) begin
      check("t5_period", acc[i] - acc[i-1], 18);
    end
    wait_valid(edges, busy_all);
    check("t5_out", 32'(bus_if.out), 32'h5A5A);
    @(negedge clk);
    bus_if.out_ready = 1'b0;

    // Random operands with random consumer stalls.
    for (int n = 0; n < 1000; n++) begin
      av = W'($urandom_range(0, 16'hFFFF));
      bv = W'($urandom_range(0, 16'hFFFF));
      exp_q.push_back(av | bv);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(av, bv);
      done  = 1'b0;
      guard = 0;
      while (!done && guard < WAIT_MAX) begin
        bus_if.out_ready = ($urandom_range(0, 3) != 0);
        if (bus_if.out_valid && bus_if.out_ready) begin
          got = bus_if.out;
          check("rand_out", 32'(got), 32'(exp_q.pop_front()));
          done = 1'b1;
        end
        @(negedge clk);
        guard++;
      end
      check("rand_handshake", 32'(done), 1);
    end
    bus_if.out_ready = 1'b0;
    check("rand_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
